// File: rtl/fifo_sync_if.sv
// FIFO access bundle: write side, read side and status outputs.
interface fifo_sync_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    // User side of the FIFO.
    modport master (
        output wdata, winc, rinc,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wdata, winc, rinc,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy counter, almost-full/empty flags, sticky
// overflow/underflow, and selectable first-word-fall-through or registered read.
module fifo_sync #(
    parameter int unsigned DSIZE      = 8,
    parameter int unsigned ASIZE      = 4,
    parameter int unsigned AFULL_THR  = (1 << ASIZE) - 2,
    parameter int unsigned AEMPTY_THR = 2,
    parameter bit          FWFT       = 1'b1
) (
    input logic        clk,
    input logic        reset,
    fifo_sync_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full, empty, wen, ren;

    // Flags depend only on the registered count, never on winc/rinc.
    assign full  = (count_q == (ASIZE + 1)'(DEPTH));
    assign empty = (count_q == '0);

    // Requests in the reset cycle are dropped, so memory is never written then.
    assign wen = bus.winc && !full && !reset;
    assign ren = bus.rinc && !empty && !reset;

    // Next-state for pointers, occupancy and sticky error bits.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (bus.winc & full);
        underflow_d = underflow_q | (bus.rinc & empty);
        if (wen) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (ren) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wen, ren})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[wptr_q] <= bus.wdata;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is visible as soon as it is stored.
        assign bus.rdata = mem_q[rptr_q];
    end else begin : g_reg_read
        logic [DSIZE-1:0] rdata_q;

        // Registered read: capture the head on an accepted read, hold otherwise.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (ren) begin
                rdata_q <= mem_q[rptr_q];
            end
        end

        assign bus.rdata = rdata_q;
    end

    assign bus.wfull         = full;
    assign bus.rempty        = empty;
    assign bus.walmost_full  = (count_q >= (ASIZE + 1)'(AFULL_THR));
    assign bus.ralmost_empty = (count_q <= (ASIZE + 1)'(AEMPTY_THR));
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data width in bits.
REQ-002 SHALL have parameter ASIZE, default 4: address width; DEPTH = 1<<ASIZE entries.
REQ-003 SHALL have parameter AFULL_THR, default DEPTH-2: almost-full threshold, 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_THR, default 2: almost-empty threshold, 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through, 0 = registered read.
REQ-006 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port wdata  input  DSIZE  write data.
REQ-009 SHALL have port winc  input  1  write request.
REQ-010 SHALL have port wfull  output  1  FIFO full.
REQ-011 SHALL have port walmost_full  output  1  count >= AFULL_THR.
REQ-012 SHALL have port rinc  input  1  read request.
REQ-013 SHALL have port rdata  output  DSIZE  read data.
REQ-014 SHALL have port rempty  output  1  FIFO empty.
REQ-015 SHALL have port ralmost_empty  output  1  count <= AEMPTY_THR.
REQ-016 SHALL have port count  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-018 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 SHALL accept a write (wen) iff winc && !wfull; wdata stored at wptr, wptr += 1 mod DEPTH.
REQ-020 SHALL accept a read (ren) iff rinc && !rempty; rptr += 1 mod DEPTH.
REQ-021 SHALL hold wptr/rptr at ASIZE bits, wrapping DEPTH-1 -> 0 with no gap or lost entry.
REQ-022 SHALL update count next cycle: +1 on wen only, -1 on ren only, unchanged on both or neither.
REQ-023 SHALL derive wfull = (count==DEPTH), rempty = (count==0), walmost_full, ralmost_empty from registered count only; no combinational path from winc/rinc to any flag.
REQ-024 SHALL, when full with winc and rinc both high: accept the read, reject the write, set overflow; count -> DEPTH-1.
REQ-025 SHALL, when empty with winc and rinc both high: accept the write, reject the read, set underflow; count -> 1.
REQ-026 SHALL leave memory, pointers and count unchanged on a rejected write or read.
REQ-027 SHALL, with FWFT=1, drive rdata = mem[rptr] combinationally; head word valid whenever !rempty; read latency 0.
REQ-028 SHALL, with FWFT=0, register rdata <= mem[rptr] on ren; rdata valid the cycle after ren and held until next ren.
REQ-029 SHALL set overflow on winc && wfull and underflow on rinc && rempty; both remain set until reset.
REQ-030 SHALL preserve FIFO order: reads return words in exact write order across any number of wraps.

Reset
REQ-031 SHALL, on clk edge with reset=1, set wptr=0, rptr=0, count=0, overflow=0, underflow=0; resulting rempty=1, wfull=0, walmost_full=0, ralmost_empty=1.
REQ-032 SHALL clear registered rdata to 0 when FWFT=0; rdata is don't-care while rempty when FWFT=1.
REQ-033 SHALL not reset memory contents; reset mid-operation discards all stored words, and any winc/rinc in the reset cycle is ignored.

Verification (DSIZE=8, ASIZE=2, DEPTH=4, AFULL_THR=3, AEMPTY_THR=1)
REQ-034 SHALL cover: reset, write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; walmost_full at count 3; wfull at 4; reads return 0x11..0x44 in order; rempty after 4th read.
REQ-035 SHALL cover: full FIFO, winc=rinc=1 one cycle -> 0x11 read, write rejected, count=3, overflow=1 and sticky.
REQ-036 SHALL cover: empty FIFO, winc=rinc=1, wdata=0xA5 -> count=1, underflow=1, head = 0xA5 (FWFT=1 immediately; FWFT=0 after next ren).
REQ-037 SHALL cover: 10 write/read pairs with data 0..9 -> pointers wrap twice, read data 0..9 in order, count stays 0/1, no overflow/underflow.
REQ-038 SHALL cover: FWFT=0, write 0x5A, pulse rinc -> rdata=0x5A exactly one cycle later and held while rinc=0.
REQ-039 SHALL cover: reset asserted at count=3 -> next cycle count=0, rempty=1, flags and sticky bits cleared, then writes resume from address 0.
